int_ack_sequencer: RTL and testbench

INT_ACK_SEQUENCER -- requirements
Module: int_ack_sequencer

---
 rtl/int_ack_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_int_ack_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_ack_sequencer.sv
// Fixed-priority interrupt acknowledge sequencer: nesting, two-pulse INTA vector cycle, EOI handling.
// Define AUTO_EOI_EN to clear the acknowledged isr bit automatically when INTA completes.
module int_ack_sequencer #(
  parameter logic [4:0] VECTOR_BASE = 5'b00100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr_in,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       eoi,
  input  logic       vec_base_ld,
  input  logic [4:0] vec_base,
  output logic       int_out,
  output logic [7:0] clear_irr,
  output logic       freeze,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_t;

  state_t     state_reg, state_next;
  logic       inta_prev_reg;
  logic [4:0] base_reg, base_pend_reg;
  logic       base_pend_valid_reg;
  logic [2:0] index_reg, index_next;
  logic       int_out_reg, int_out_next;
  logic       freeze_reg, freeze_next;
  logic       data_oe_reg, data_oe_next;
  logic [7:0] clear_irr_reg, clear_irr_next;
  logic [7:0] isr_reg, isr_next;
  logic [7:0] data_out_reg, data_out_next;

  logic [7:0] pending, allow, qual;
  logic       qual_any, win_valid, inta_fall, inta_rise;
  logic [2:0] win_idx;
  logic [7:0] set_mask, eoi_mask, auto_clr, isr_lowest;

  assign pending   = irr_in & ~imr;
  assign inta_fall = inta_prev_reg & ~inta_n;
  assign inta_rise = ~inta_prev_reg & inta_n;

  // A bit qualifies only when no isr bit of equal or higher priority is set.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gen_allow
      assign allow[gi] = ~|isr_reg[gi:0];
    end
  endgenerate

  assign qual       = pending & allow;
  assign qual_any   = |qual;
  assign isr_lowest = isr_reg & (~isr_reg + 8'd1);
  assign eoi_mask   = eoi ? isr_lowest : 8'h00;

  always_comb begin
    win_idx   = 3'd7;
    win_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (qual[i]) begin
        win_idx   = 3'(i);
        win_valid = 1'b1;
      end
    end
  end

`ifdef AUTO_EOI_EN
  logic [7:0] ack_mask_reg;
  always_ff @(posedge clk) begin
    if (reset)                    ack_mask_reg <= 8'h00;
    else if (state_next == ACK1 && state_reg == REQ) ack_mask_reg <= set_mask;
  end
`endif

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    int_out_next   = int_out_reg;
    freeze_next    = freeze_reg;
    data_oe_next   = data_oe_reg;
    data_out_next  = data_out_reg;
    clear_irr_next = 8'h00;
    set_mask       = 8'h00;
    auto_clr       = 8'h00;
    case (state_reg)
      IDLE: begin
        if (qual_any) begin
          state_next   = REQ;
          int_out_next = 1'b1;
        end
      end
      REQ: begin
        if (inta_fall) begin
          // With no winner the cycle is spurious: index 7, nothing set or cleared.
          state_next     = ACK1;
          int_out_next   = 1'b0;
          freeze_next    = 1'b1;
          index_next     = win_idx;
          set_mask       = win_valid ? (8'd1 << win_idx) : 8'h00;
          clear_irr_next = set_mask;
        end else if (!qual_any) begin
          state_next   = IDLE;
          int_out_next = 1'b0;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_next    = ACK2;
          data_out_next = {base_reg, index_reg};
          data_oe_next  = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_next    = IDLE;
          freeze_next   = 1'b0;
          data_oe_next  = 1'b0;
          data_out_next = 8'h00;
`ifdef AUTO_EOI_EN
          auto_clr      = ack_mask_reg;
`else
          auto_clr      = 8'h00;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    isr_next = (isr_reg & ~eoi_mask & ~auto_clr) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      inta_prev_reg <= 1'b1;
      index_reg     <= 3'd0;
      int_out_reg   <= 1'b0;
      freeze_reg    <= 1'b0;
      data_oe_reg   <= 1'b0;
      clear_irr_reg <= 8'h00;
      isr_reg       <= 8'h00;
      data_out_reg  <= 8'h00;
    end else begin
      state_reg     <= state_next;
      inta_prev_reg <= inta_n;
      index_reg     <= index_next;
      int_out_reg   <= int_out_next;
      freeze_reg    <= freeze_next;
      data_oe_reg   <= data_oe_next;
      clear_irr_reg <= clear_irr_next;
      isr_reg       <= isr_next;
      data_out_reg  <= data_out_next;
    end
  end

  // A base load arriving while the vector is driven is parked until the cycle ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_reg            <= VECTOR_BASE;
      base_pend_reg       <= VECTOR_BASE;
      base_pend_valid_reg <= 1'b0;
    end else if (vec_base_ld && state_reg == ACK2) begin
      base_pend_reg       <= vec_base;
      base_pend_valid_reg <= 1'b1;
    end else if (vec_base_ld) begin
      base_reg            <= vec_base;
      base_pend_valid_reg <= 1'b0;
    end else if (base_pend_valid_reg && state_reg != ACK2) begin
      base_reg            <= base_pend_reg;
      base_pend_valid_reg <= 1'b0;
    end
  end

  assign int_out   = int_out_reg;
  assign clear_irr = clear_irr_reg;
  assign freeze    = freeze_reg;
  assign isr       = isr_reg;
  assign data_out  = data_out_reg;
  assign data_oe   = data_oe_reg;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Self-checking bench for int_ack_sequencer: directed scenarios plus randomized acknowledge cycles
// compared against a priority/nesting reference model.
module tb_int_ack_sequencer;

  localparam logic [4:0] BASE0 = 5'b00100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr_in, imr;
  logic       inta_n, eoi, vec_base_ld;
  logic [4:0] vec_base;
  logic       int_out, freeze, data_oe;
  logic [7:0] clear_irr, isr, data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_isr;
  logic [4:0] model_base;

  int_ack_sequencer #(.VECTOR_BASE(BASE0)) dut (
    .clk(clk), .reset(reset), .irr_in(irr_in), .imr(imr), .inta_n(inta_n),
    .eoi(eoi), .vec_base_ld(vec_base_ld), .vec_base(vec_base),
    .int_out(int_out), .clear_irr(clear_irr), .freeze(freeze), .isr(isr),
    .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Highest-priority request that outranks everything already in service; 8 = none.
  function automatic int winner(input logic [7:0] pend, input logic [7:0] cur_isr);
    for (int i = 0; i < 8; i++) begin
      if (cur_isr[i]) return 8;
      if (pend[i]) return i;
    end
    return 8;
  endfunction

  function automatic logic [7:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  task automatic full_ack(input logic [7:0] irr_v, input logic [7:0] imr_v, input bit withdraw,
                          input bit eoi_ack, input bit ld_ack2, input logic [4:0] ld_val);
    int w, w2;
    logic [7:0] clr;
    logic [2:0] idx;
    irr_in = irr_v;
    imr    = imr_v;
    w = winner(irr_v & ~imr_v, model_isr);
    tick();
    check("req_int_out", 8'(int_out), 8'(w < 8));
    inta_n = 1'b0;
    if (withdraw) irr_in = 8'h00;
    if (eoi_ack) eoi = 1'b1;
    w2  = winner(irr_in & ~imr, model_isr);
    clr = (w2 < 8) ? 8'(1 << w2) : 8'h00;
    idx = (w2 < 8) ? 3'(w2) : 3'd7;
    if (eoi_ack) model_isr = model_isr & ~lowest(model_isr);
    model_isr = model_isr | clr;
    tick();
    eoi = 1'b0;
    check("ack1_isr", isr, model_isr);
    check("ack1_clear_irr", clear_irr, clr);
    check("ack1_freeze", 8'(freeze), 8'd1);
    check("ack1_int_out", 8'(int_out), 8'd0);
    irr_in = irr_in & ~clr;
    inta_n = 1'b1;
    tick();
    check("ack1_clear_one_cycle", clear_irr, 8'h00);
    inta_n = 1'b0;
    tick();
    check("ack2_data_out", data_out, {model_base, idx});
    check("ack2_data_oe", 8'(data_oe), 8'd1);
    if (ld_ack2) begin
      vec_base_ld = 1'b1;
      vec_base    = ld_val;
      tick();
      vec_base_ld = 1'b0;
      check("ack2_data_hold", data_out, {model_base, idx});
    end
    inta_n = 1'b1;
    irr_in = 8'h00;
    tick();
    if (ld_ack2) model_base = ld_val;
`ifdef AUTO_EOI_EN
    model_isr = model_isr & ~clr;
`endif
    check("done_freeze", 8'(freeze), 8'd0);
    check("done_data_oe", 8'(data_oe), 8'd0);
    check("done_data_out", data_out, 8'h00);
    check("done_isr", isr, model_isr);
  endtask

  task automatic do_eoi();
    irr_in = 8'h00;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    model_isr = model_isr & ~lowest(model_isr);
    check("eoi_isr", isr, model_isr);
  endtask

  initial begin
    reset = 1'b1; irr_in = 8'h00; imr = 8'h00; inta_n = 1'b1; eoi = 1'b0;
    vec_base_ld = 1'b0; vec_base = 5'd0;
    model_isr = 8'h00; model_base = BASE0;
    tick(); tick();
    check("rst_int_out", 8'(int_out), 8'd0);
    check("rst_freeze", 8'(freeze), 8'd0);
    check("rst_data_oe", 8'(data_oe), 8'd0);
    check("rst_clear_irr", clear_irr, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    reset = 1'b0;
    tick();

    // Basic acknowledge of IR2 out of 8'h24, vector 8'h22.
    full_ack(8'h24, 8'h00, 0, 0, 0, 5'd0);
`ifndef AUTO_EOI_EN
    check("basic_isr_literal", isr, 8'h04);
    // Nested IR0 over IR2, then IR3 must not interrupt IR2.
    full_ack(8'h01, 8'h00, 0, 0, 0, 5'd0);
    check("nested_isr_literal", isr, 8'h05);
    do_eoi();
    irr_in = 8'h08;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lower_blocked", 8'(int_out), 8'd0);
    end
    irr_in = 8'h00;
    // isr 06 -> eoi -> 04; eoi coincident with IR0 acknowledge -> 05.
    full_ack(8'h02, 8'h00, 0, 0, 0, 5'd0);
    do_eoi();
    check("eoi_literal", isr, 8'h04);
    full_ack(8'h02, 8'h00, 0, 0, 0, 5'd0);
    full_ack(8'h01, 8'h00, 0, 1, 0, 5'd0);
    check("eoi_ack1_literal", isr, 8'h05);
    do_eoi(); do_eoi(); do_eoi();
`else
    check("auto_eoi_literal", isr, 8'h00);
`endif
    do_eoi();  // isr empty: no effect

    // Spurious: request withdrawn at the first INTA edge.
    full_ack(8'h10, 8'h00, 1, 0, 0, 5'd0);

    // Base load parked during ACK2, then used by the next vector; then a load while idle.
    full_ack(8'h08, 8'h00, 0, 0, 1, 5'b11001);
    do_eoi();
    full_ack(8'h40, 8'h00, 0, 0, 0, 5'd0);
    do_eoi();
    vec_base_ld = 1'b1; vec_base = 5'b01010;
    tick();
    vec_base_ld = 1'b0; model_base = 5'b01010;
    full_ack(8'h08, 8'h00, 0, 0, 0, 5'd0);
    do_eoi();

    // Reset while the vector is being driven.
    irr_in = 8'h02;
    tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    check("pre_reset_data_oe", 8'(data_oe), 8'd1);
    reset = 1'b1;
    tick();
    check("rst_ack2_int_out", 8'(int_out), 8'd0);
    check("rst_ack2_freeze", 8'(freeze), 8'd0);
    check("rst_ack2_data_oe", 8'(data_oe), 8'd0);
    check("rst_ack2_data_out", data_out, 8'h00);
    check("rst_ack2_clear_irr", clear_irr, 8'h00);
    check("rst_ack2_isr", isr, 8'h00);
    reset = 1'b0; inta_n = 1'b1; irr_in = 8'h00;
    model_isr = 8'h00; model_base = BASE0;
    tick();
    check("post_reset_data_oe", 8'(data_oe), 8'd0);

    // Fully masked requests never raise int_out.
    irr_in = 8'hFF; imr = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("masked_int_out", 8'(int_out), 8'd0);
    end
    irr_in = 8'h00; imr = 8'h00;
    tick();

    // Randomized acknowledge cycles.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] r_irr, r_imr;
      r_irr = 8'($urandom_range(1, 255));
      r_imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if (winner(r_irr & ~r_imr, model_isr) < 8) begin
        full_ack(r_irr, r_imr, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, 5'($urandom));
      end else begin
        irr_in = r_irr; imr = r_imr;
        tick();
        check("rand_blocked", 8'(int_out), 8'd0);
        irr_in = 8'h00;
        tick();
      end
      if ($urandom_range(0, 1) == 1) do_eoi();
      if ($urandom_range(0, 7) == 0) begin
        vec_base_ld = 1'b1; vec_base = 5'($urandom);
        tick();
        vec_base_ld = 1'b0; model_base = vec_base;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
